quot_bcd_conv: RTL

Sequential binary-to-BCD converter for the divider's 21-bit quotient. It sits directly downstream of `divider`: it captures `opt` on a start pulse and converts it with shift-add-3 (double dabble), one bit per clock. It presents packed BCD digits to the display/readout stage with a one-cycle `done` pulse.

---
 rtl/quot_bcd_conv_if.sv | 33 +++
 rtl/quot_bcd_conv.sv | 121 ++++++++++++
 2 files changed

// File: rtl/quot_bcd_conv_if.sv
// quot_bcd_conv_if
//   Bundles the request and result signals of quot_bcd_conv.
//   master : producer side (the divider/testbench) drives start and bin,
//            and observes busy, done, bcd and blank.
//   slave  : the converter itself.
//   Signals:
//     start  request; the converter samples it only while idle
//     bin    unsigned binary value to convert (WIDTH bits)
//     busy   high while a conversion is running
//     done   one-cycle pulse when bcd/blank are updated
//     bcd    packed BCD result; digit 0 (units) in bits [3:0]
//     blank  leading-zero mask, one bit per digit
interface quot_bcd_conv_if #(
  parameter int unsigned WIDTH  = 21,
  parameter int unsigned DIGITS = 7
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, bin,
    input  busy, done, bcd, blank
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, blank
  );
endinterface

// File: rtl/quot_bcd_conv.sv
// quot_bcd_conv
//   Sequential binary-to-BCD converter for the divider's quotient.
//   Captures bin on start (while idle) and runs double dabble, one bit per
//   clock; after WIDTH shifts bcd/blank are updated and done pulses once.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset, clears all state
//     bus    quot_bcd_conv_if.slave (start, bin in; busy, done, bcd, blank out)
//   Build option:
//     QUOT_BCD_BLANK_EN  when defined, blank[i] (i>=1) flags digit i and all
//                        higher digits as zero; blank[0] is always 0.
//                        When undefined, blank is constant zero.
module quot_bcd_conv #(
  parameter int unsigned WIDTH  = 21,
  parameter int unsigned DIGITS = 7
) (
  input logic             clk,
  input logic             reset,
  quot_bcd_conv_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    sh_q;
  logic [BW-1:0]       acc_q;
  logic                busy_q;
  logic                done_q;
  logic [BW-1:0]       bcd_q;

  logic [BW-1:0]       acc_adj;
  logic [BW+WIDTH-1:0] cat_shl;
  logic [BW-1:0]       acc_d;
  logic [WIDTH-1:0]    sh_d;

  // Add-3 on every digit >= 5, then shift {accumulator, shift register}
  // left as one vector so the shift register's MSB enters digit 0.
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    cat_shl = {acc_adj, sh_q} << 1;
    acc_d   = cat_shl[BW+WIDTH-1:WIDTH];
    sh_d    = cat_shl[WIDTH-1:0];
  end

`ifdef QUOT_BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              hi_zero;

  // Scan from the top digit down; the units digit is never blanked.
  always_comb begin
    blank_d = '0;
    hi_zero = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      hi_zero    = hi_zero & (acc_d[4*i +: 4] == 4'd0);
      blank_d[i] = hi_zero;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
`ifdef QUOT_BCD_BLANK_EN
      blank_q <= BLANK_RST;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            sh_q    <= bus.bin;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= acc_d;
`ifdef QUOT_BCD_BLANK_EN
            blank_q <= blank_d;
`endif
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
`ifdef QUOT_BCD_BLANK_EN
  assign bus.blank = blank_q;
`else
  assign bus.blank = '0;
`endif
endmodule
